// File: rtl/barra_ctrl.sv
// Multi-channel paddle-position controller: per-channel manual/auto command decode,
// direction FSM with speed ramp, and saturating moves at the playfield limits.
module barra_ctrl #(
  parameter int N         = 2,
  parameter int W         = 10,
  parameter int MIN       = 30,
  parameter int MAX       = 329,
  parameter int CENTER    = 180,
  parameter int DELTA_MIN = 1,
  parameter int DELTA_MAX = 4,
  parameter int RAMP      = 4,
  parameter int DEAD      = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           recenter,
  input  logic [N-1:0]   up,
  input  logic [N-1:0]   down,
  input  logic [N-1:0]   auto,
  input  logic [W-1:0]   ball_y,
  output logic [N*W-1:0] y,
  output logic [N-1:0]   moving,
  output logic [N-1:0]   at_limit
);

  localparam int CW = (RAMP > 1) ? $clog2(RAMP) : 1;

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_UP, CMD_DOWN} cmd_t;

  state_t         state [N];
  state_t         state_next [N];
  cmd_t           cmd [N];
  logic [W-1:0]   pos [N];
  logic [W-1:0]   pos_next [N];
  logic [W-1:0]   spd [N];
  logic [W-1:0]   spd_next [N];
  logic [W-1:0]   step [N];
  logic [CW-1:0]  cnt [N];
  logic [CW-1:0]  cnt_next [N];
  logic [N-1:0]   moving_next;
  logic [W:0]     ball_ext;

  function automatic logic [W-1:0] sat_up(input logic [W-1:0] p, input logic [W-1:0] s);
    logic [W:0] sum;
    sum = {1'b0, p} + {1'b0, s};
    return (sum > (W+1)'(MAX)) ? W'(MAX) : sum[W-1:0];
  endfunction

  function automatic logic [W-1:0] sat_down(input logic [W-1:0] p, input logic [W-1:0] s);
    logic [W:0] lim;
    lim = (W+1)'(MIN) + {1'b0, s};
    return ({1'b0, p} < lim) ? W'(MIN) : p - s;
  endfunction

  assign ball_ext = {1'b0, ball_y};

  always_comb begin
    moving_next = moving;
    for (int i = 0; i < N; i++) begin
      pos_next[i]   = pos[i];
      state_next[i] = state[i];
      spd_next[i]   = spd[i];
      cnt_next[i]   = cnt[i];
      cmd[i]        = CMD_NONE;
      step[i]       = W'(DELTA_MIN);

      if (auto[i]) begin
        if (ball_ext > {1'b0, pos[i]} + (W+1)'(DEAD))
          cmd[i] = CMD_UP;
        else if (ball_ext + (W+1)'(DEAD) < {1'b0, pos[i]})
          cmd[i] = CMD_DOWN;
      end else if (up[i] && !down[i]) begin
        cmd[i] = CMD_UP;
      end else if (down[i] && !up[i]) begin
        cmd[i] = CMD_DOWN;
      end

      // Continuing in the same direction uses the ramped speed; anything else restarts slow.
      if ((cmd[i] == CMD_UP && state[i] == MOVE_UP) ||
          (cmd[i] == CMD_DOWN && state[i] == MOVE_DOWN))
        step[i] = spd[i];

      if (recenter) begin
        pos_next[i]    = W'(CENTER);
        state_next[i]  = IDLE;
        spd_next[i]    = W'(DELTA_MIN);
        cnt_next[i]    = '0;
        moving_next[i] = 1'b0;
      end else if (tick) begin
        if (cmd[i] == CMD_NONE ||
            (cmd[i] == CMD_UP && pos[i] == W'(MAX)) ||
            (cmd[i] == CMD_DOWN && pos[i] == W'(MIN))) begin
          state_next[i] = IDLE;
          spd_next[i]   = W'(DELTA_MIN);
          cnt_next[i]   = '0;
        end else begin
          pos_next[i] = (cmd[i] == CMD_UP) ? sat_up(pos[i], step[i])
                                           : sat_down(pos[i], step[i]);
          if (step[i] == spd[i] && state[i] != IDLE &&
              ((cmd[i] == CMD_UP) == (state[i] == MOVE_UP))) begin
            if (RAMP == 1 || cnt[i] == CW'(RAMP - 1)) begin
              cnt_next[i] = '0;
              spd_next[i] = (spd[i] >= W'(DELTA_MAX)) ? W'(DELTA_MAX) : spd[i] + 1'b1;
            end else begin
              cnt_next[i] = cnt[i] + 1'b1;
            end
          end else begin
            state_next[i] = (cmd[i] == CMD_UP) ? MOVE_UP : MOVE_DOWN;
            spd_next[i]   = W'(DELTA_MIN);
            cnt_next[i]   = CW'(1);
          end
        end
        moving_next[i] = (pos_next[i] != pos[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      moving <= '0;
      for (int i = 0; i < N; i++) begin
        pos[i]   <= W'(CENTER);
        state[i] <= IDLE;
        spd[i]   <= W'(DELTA_MIN);
        cnt[i]   <= '0;
      end
    end else begin
      moving <= moving_next;
      for (int i = 0; i < N; i++) begin
        pos[i]   <= pos_next[i];
        state[i] <= state_next[i];
        spd[i]   <= spd_next[i];
        cnt[i]   <= cnt_next[i];
      end
    end
  end

  always_comb begin
    y        = '0;
    at_limit = '0;
    for (int i = 0; i < N; i++) begin
      y[i*W +: W] = pos[i];
      at_limit[i] = (pos[i] == W'(MIN)) || (pos[i] == W'(MAX));
    end
  end

endmodule

// File: tb/tb_barra_ctrl.sv
// Directed bench for barra_ctrl: reset, ramp, reversal, limits, auto-track, recenter.
module tb_barra_ctrl;
  localparam int N = 2;
  localparam int W = 10;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           tick = 1'b0;
  logic           recenter = 1'b0;
  logic [N-1:0]   up = '0;
  logic [N-1:0]   down = '0;
  logic [N-1:0]   auto = '0;
  logic [W-1:0]   ball_y = '0;
  logic [N*W-1:0] y;
  logic [N-1:0]   moving;
  logic [N-1:0]   at_limit;
  logic [W-1:0]   y0, y1;

  int n_pass = 0;
  int n_total = 0;

  assign y0 = y[W-1:0];
  assign y1 = y[2*W-1:W];

  barra_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .recenter(recenter),
    .up(up), .down(down), .auto(auto), .ball_y(ball_y),
    .y(y), .moving(moving), .at_limit(at_limit)
  );

  always #5 clk = ~clk;

  // All stimulus tasks start and end on a falling edge.
  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (y0 !== 10'd180) $display("FAIL reset_y0 got %0d want 180", y0); else n_pass++;
    n_total++; if (y1 !== 10'd180) $display("FAIL reset_y1 got %0d want 180", y1); else n_pass++;
    n_total++; if (moving !== 2'b00) $display("FAIL reset_moving got %b want 00", moving); else n_pass++;
    n_total++; if (at_limit !== 2'b00) $display("FAIL reset_at_limit got %b want 00", at_limit); else n_pass++;
    up = 2'b11; @(negedge clk);
    up = 2'b00; down = 2'b11; @(negedge clk);
    down = 2'b00; @(negedge clk);
    n_total++; if (y !== {10'd180, 10'd180}) $display("FAIL notick_hold got %h want %h", y, {10'd180, 10'd180}); else n_pass++;
    n_total++; if (moving !== 2'b00) $display("FAIL notick_moving got %b want 00", moving); else n_pass++;
  endtask

  task automatic test_ramp;
    int exp_y[14] = '{181, 182, 183, 184, 186, 188, 190, 192, 195, 198, 201, 204, 208, 212};
    up = 2'b01;
    for (int k = 0; k < 14; k++) begin
      tick_n(1);
      n_total++;
      if (y0 !== 10'(exp_y[k])) $display("FAIL ramp_y0_t%0d got %0d want %0d", k + 1, y0, exp_y[k]);
      else n_pass++;
    end
    n_total++; if (moving !== 2'b01) $display("FAIL ramp_moving got %b want 01", moving); else n_pass++;
    n_total++; if (y1 !== 10'd180) $display("FAIL ramp_y1 got %0d want 180", y1); else n_pass++;
  endtask

  task automatic test_reverse;
    up = 2'b00; down = 2'b01;
    tick_n(1);
    n_total++; if (y0 !== 10'd211) $display("FAIL reverse_first got %0d want 211", y0); else n_pass++;
    tick_n(1);
    n_total++; if (y0 !== 10'd210) $display("FAIL reverse_second got %0d want 210", y0); else n_pass++;
    up = 2'b01;
    tick_n(1);
    n_total++; if (y0 !== 10'd210) $display("FAIL both_hold got %0d want 210", y0); else n_pass++;
    n_total++; if (moving !== 2'b00) $display("FAIL both_moving got %b want 00", moving); else n_pass++;
    down = 2'b00;
    tick_n(1);
    n_total++; if (y0 !== 10'd211) $display("FAIL speed_reset got %0d want 211", y0); else n_pass++;
  endtask

  task automatic test_limits;
    int cnt;
    logic [W-1:0] prev;
    up = 2'b01; cnt = 0; prev = y0;
    while (y0 != 10'd329 && cnt < 100) begin
      prev = y0;
      tick_n(1);
      cnt++;
    end
    n_total++; if (cnt !== 35) $display("FAIL top_ticks got %0d want 35", cnt); else n_pass++;
    n_total++; if (prev !== 10'd326) $display("FAIL top_prev got %0d want 326", prev); else n_pass++;
    n_total++; if (at_limit !== 2'b01) $display("FAIL top_at_limit got %b want 01", at_limit); else n_pass++;
    n_total++; if (moving !== 2'b01) $display("FAIL top_moving got %b want 01", moving); else n_pass++;
    tick_n(1);
    n_total++; if (y0 !== 10'd329) $display("FAIL top_hold got %0d want 329", y0); else n_pass++;
    n_total++; if (moving !== 2'b00) $display("FAIL top_hold_moving got %b want 00", moving); else n_pass++;
    up = 2'b00; down = 2'b01; cnt = 0;
    while (y0 != 10'd30 && cnt < 200) begin
      prev = y0;
      tick_n(1);
      cnt++;
    end
    n_total++; if (cnt !== 81) $display("FAIL bot_ticks got %0d want 81", cnt); else n_pass++;
    n_total++; if (prev !== 10'd33) $display("FAIL bot_prev got %0d want 33", prev); else n_pass++;
    n_total++; if (at_limit !== 2'b01) $display("FAIL bot_at_limit got %b want 01", at_limit); else n_pass++;
    tick_n(1);
    n_total++; if (y0 !== 10'd30) $display("FAIL bot_hold got %0d want 30", y0); else n_pass++;
    n_total++; if (moving !== 2'b00) $display("FAIL bot_hold_moving got %b want 00", moving); else n_pass++;
    down = 2'b00;
  endtask

  task automatic test_auto;
    auto = 2'b10; ball_y = 10'd250; down = 2'b10;
    tick_n(23);
    n_total++; if (y1 !== 10'd248) $display("FAIL auto_track got %0d want 248", y1); else n_pass++;
    n_total++; if (moving !== 2'b10) $display("FAIL auto_moving got %b want 10", moving); else n_pass++;
    tick_n(1);
    n_total++; if (y1 !== 10'd248) $display("FAIL auto_stop got %0d want 248", y1); else n_pass++;
    n_total++; if (moving !== 2'b00) $display("FAIL auto_stop_moving got %b want 00", moving); else n_pass++;
    n_total++; if (y0 !== 10'd30) $display("FAIL auto_ch0_idle got %0d want 30", y0); else n_pass++;
    recenter = 1'b1; @(negedge clk); recenter = 1'b0;
    ball_y = 10'd179;
    tick_n(1);
    n_total++; if (y1 !== 10'd180) $display("FAIL deadband got %0d want 180", y1); else n_pass++;
    ball_y = 10'd177;
    tick_n(1);
    n_total++; if (y1 !== 10'd179) $display("FAIL auto_down got %0d want 179", y1); else n_pass++;
    auto = 2'b00; down = 2'b00;
  endtask

  task automatic test_recenter;
    recenter = 1'b1; @(negedge clk); recenter = 1'b0;
    up = 2'b01;
    tick_n(6);
    n_total++; if (y0 !== 10'd188) $display("FAIL pre_recenter got %0d want 188", y0); else n_pass++;
    recenter = 1'b1; tick = 1'b1;
    @(negedge clk);
    recenter = 1'b0; tick = 1'b0;
    n_total++; if (y !== {10'd180, 10'd180}) $display("FAIL recenter_y got %h want %h", y, {10'd180, 10'd180}); else n_pass++;
    n_total++; if (moving !== 2'b00) $display("FAIL recenter_moving got %b want 00", moving); else n_pass++;
    tick_n(1);
    n_total++; if (y0 !== 10'd181) $display("FAIL recenter_step got %0d want 181", y0); else n_pass++;
    tick_n(4);
    n_total++; if (y0 !== 10'd186) $display("FAIL pre_reset got %0d want 186", y0); else n_pass++;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_total++; if (y0 !== 10'd180) $display("FAIL async_reset_y0 got %0d want 180", y0); else n_pass++;
    n_total++; if (moving !== 2'b00) $display("FAIL async_reset_moving got %b want 00", moving); else n_pass++;
    @(negedge clk);
    reset = 1'b0; up = 2'b00;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ramp();
    test_reverse();
    test_limits();
    test_auto();
    test_recenter();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
